demux_1x8_seq: RTL and testbench

DEMUX_1X8_SEQ -- requirements
Module: demux_1x8_seq

---
 rtl/demux_1x8_seq.sv | 124 ++++++++++++
 tb/tb_demux_1x8_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/demux_1x8_seq.sv
// 1-to-8 registered demultiplexer with manual select and an auto-scan mode.
// Auto-scan writes successive valid bits to outputs a..h and pulses frame_done when the frame completes.
module demux_1x8_seq #(
    parameter bit CLEAR_UNSELECTED = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       s,
    input  logic       s1,
    input  logic       s2,
    input  logic       mode,
    input  logic       start,
    input  logic       valid,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] ptr
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] out_q, out_d;
    logic [2:0] ptr_q, ptr_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;

    logic [2:0] sel;
    logic       wr_en;
    logic [2:0] wr_idx;

    assign sel = {s2, s1, s};

    // A mode drop during SCAN aborts the frame but still honours that cycle's manual write.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        frame_done_d = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = sel;

        case (state_q)
            IDLE: begin
                ptr_d = 3'd0;
                if (mode) begin
                    if (start) begin
                        state_d = SCAN;
                    end
                end else begin
                    wr_en = valid;
                end
            end
            SCAN: begin
                if (!mode) begin
                    state_d = IDLE;
                    ptr_d   = 3'd0;
                    wr_en   = valid;
                end else if (valid) begin
                    wr_en  = 1'b1;
                    wr_idx = ptr_q;
                    ptr_d  = ptr_q + 3'd1;
                    if (ptr_q == 3'd7) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = 3'd0;
            end
        endcase

        busy_d = (state_d == SCAN);

        out_d = out_q;
        if (wr_en) begin
            if (CLEAR_UNSELECTED) begin
                out_d = 8'h00;
            end
            out_d[wr_idx] = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            out_q        <= 8'h00;
            ptr_q        <= 3'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            ptr_q        <= ptr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign a          = out_q[0];
    assign b          = out_q[1];
    assign c          = out_q[2];
    assign d          = out_q[3];
    assign e          = out_q[4];
    assign f          = out_q[5];
    assign g          = out_q[6];
    assign h          = out_q[7];
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign ptr        = ptr_q;

endmodule

// File: tb/tb_demux_1x8_seq.sv
// Scoreboard bench for demux_1x8_seq: stimulus queues hand-computed expectations, a monitor pops them after each edge.
// Expected outputs are packed a..h with a as the MSB.
module tb_demux_1x8_seq;

    logic       clk;
    logic       rst_n;
    logic       din, s, s1, s2, mode, start, valid;
    logic       a0, b0, c0, d0, e0, f0, g0, h0, busy0, fd0;
    logic [2:0] ptr0;
    logic       a1, b1, c1, d1, e1, f1, g1, h1, busy1, fd1;
    logic [2:0] ptr1;

    typedef struct {
        string      name;
        bit         which;
        logic [7:0] out;
        logic       busy;
        logic [2:0] ptr;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    demux_1x8_seq #(.CLEAR_UNSELECTED(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(din), .s(s), .s1(s1), .s2(s2),
        .mode(mode), .start(start), .valid(valid),
        .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0), .h(h0),
        .busy(busy0), .frame_done(fd0), .ptr(ptr0)
    );

    demux_1x8_seq #(.CLEAR_UNSELECTED(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .s(s), .s1(s1), .s2(s2),
        .mode(mode), .start(start), .valid(valid),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .h(h1),
        .busy(busy1), .frame_done(fd1), .ptr(ptr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input bit which, input logic [7:0] eo,
                               input logic eb, input logic [2:0] ep, input logic ef);
        logic [12:0] act, req;
        if (which)
            act = {a1, b1, c1, d1, e1, f1, g1, h1, busy1, ptr1, fd1};
        else
            act = {a0, b0, c0, d0, e0, f0, g0, h0, busy0, ptr0, fd0};
        req = {eo, eb, ep, ef};
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got out=%h busy=%b ptr=%0d fd=%b, want out=%h busy=%b ptr=%0d fd=%b",
                     name, act[12:5], act[4], act[3:1], act[0], eo, eb, ep, ef);
        end
    endtask

    task automatic applyStimulus(input string name, input bit which, input logic md, input logic st,
                                 input logic vl, input logic dn, input logic [2:0] sl,
                                 input logic [7:0] eo, input logic eb, input logic [2:0] ep,
                                 input logic ef);
        exp_t x;
        @(negedge clk);
        mode  = md;
        start = st;
        valid = vl;
        din   = dn;
        {s2, s1, s} = sl;
        x.name = name; x.which = which; x.out = eo; x.busy = eb; x.ptr = ep; x.fd = ef;
        exp_q.push_back(x);
    endtask

    // Reset is asserted away from any edge so the asynchronous clear is observed before the next clock.
    task automatic doReset(input string name);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        mode = 1'b0; start = 1'b0; valid = 1'b0; din = 1'b0; {s2, s1, s} = 3'd0;
        #1;
        checkOutput({name, "_dut0"}, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        checkOutput({name, "_dut1"}, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checkOutput(x.name, x.which, x.out, x.busy, x.ptr, x.fd);
            end
        end
    end

    initial begin
        logic [7:0] sweep_exp [8];
        logic [7:0] scan_exp  [8];
        logic       scan_din  [8];
        logic [2:0] scan_ptr  [8];

        sweep_exp = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
        scan_din  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        scan_exp  = '{8'h80, 8'h80, 8'hA0, 8'hB0, 8'hB0, 8'hB0, 8'hB2, 8'hB2};
        scan_ptr  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

        rst_n = 1'b0;
        mode = 1'b0; start = 1'b0; valid = 1'b0; din = 1'b0; {s2, s1, s} = 3'd0;
        doReset("reset_init");

        for (int i = 0; i < 8; i++)
            applyStimulus($sformatf("sweep%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'(i),
                          sweep_exp[i], 1'b0, 3'd0, 1'b0);
        applyStimulus("manual_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'hFF, 1'b0, 3'd0, 1'b0);
        applyStimulus("manual_clear_c", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'hDF, 1'b0, 3'd0, 1'b0);

        doReset("reset_pre_clear");
        applyStimulus("clr_sel3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 8'h10, 1'b0, 3'd0, 1'b0);
        applyStimulus("clr_sel5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 8'h04, 1'b0, 3'd0, 1'b0);
        applyStimulus("clr_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h04, 1'b0, 3'd0, 1'b0);

        doReset("reset_pre_scan");
        applyStimulus("scan_start", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 8'h00, 1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++)
            applyStimulus($sformatf("scan_w%0d", i), 1'b0, 1'b1, (i == 3), 1'b1, scan_din[i], 3'd7,
                          scan_exp[i], (i != 7), scan_ptr[i], (i == 7));
        applyStimulus("idle_auto_ignore", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 8'hB2, 1'b0, 3'd0, 1'b0);

        doReset("reset_pre_sparse");
        applyStimulus("sparse_start", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("sparse_w%0d", i), 1'b0, 1'b1, 1'b0, 1'b1, scan_din[i], 3'd0,
                          scan_exp[i], (i != 7), scan_ptr[i], (i == 7));
            applyStimulus($sformatf("sparse_gap%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, ~scan_din[i], 3'd0,
                          scan_exp[i], (i != 7), scan_ptr[i], 1'b0);
        end

        applyStimulus("abort_start", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'hB2, 1'b1, 3'd0, 1'b0);
        applyStimulus("abort_w0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h32, 1'b1, 3'd1, 1'b0);
        applyStimulus("abort_w1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h72, 1'b1, 3'd2, 1'b0);
        applyStimulus("abort_w2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h52, 1'b1, 3'd3, 1'b0);
        applyStimulus("abort_drop", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 8'h53, 1'b0, 3'd0, 1'b0);
        applyStimulus("abort_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h53, 1'b0, 3'd0, 1'b0);

        doReset("reset_pre_midscan");
        applyStimulus("mid_start", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++)
            applyStimulus($sformatf("mid_w%0d", i), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0,
                          sweep_exp[i], 1'b1, 3'(i + 1), 1'b0);
        doReset("reset_midscan");
        for (int i = 0; i < 3; i++)
            applyStimulus($sformatf("post_reset%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0,
                          8'h00, 1'b0, 3'd0, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL drain: got %0d entries pending, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
